// File: rtl/text_console_writer.sv
// Byte stream to 80x30 text-buffer cell writes.
// Cursor, CR/LF/BS/FF handling, edge wrap, line blanking.
module text_console_writer #(
  parameter int         COLUMNS     = 80,
  parameter int         LINES       = 30,
  parameter logic [7:0] BLANK_GLYPH = 8'h20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Data,
  input  logic [11:0] Data_Fg,
  input  logic [11:0] Data_Bg,
  input  logic        Valid,
  output logic        Ready,
  output logic [4:0]  Line,
  output logic [6:0]  Character,
  output logic [7:0]  Glyph,
  output logic [11:0] Foreground,
  output logic [11:0] Background,
  output logic        Latch
);

  typedef enum logic [1:0] {
    CLR_SCREEN,
    IDLE,
    WRITE,
    CLR_LINE
  } state_t;

  localparam logic [6:0] COL_LAST  = 7'(COLUMNS - 1);
  localparam logic [6:0] COL_END   = 7'(COLUMNS);
  localparam logic [4:0] LINE_LAST = 5'(LINES - 1);
  localparam logic [4:0] LINE_END  = 5'(LINES);

  state_t      state, state_nxt;
  logic [4:0]  cur_line;
  logic [6:0]  cur_col;
  logic [7:0]  byte_q;
  logic [11:0] fg_q, bg_q;
  logic [6:0]  scan_col;
  logic [4:0]  scan_line;

  logic        latch_nxt;
  logic [4:0]  line_nxt;
  logic [6:0]  char_nxt;
  logic [7:0]  glyph_nxt;
  logic [11:0] fg_nxt, bg_nxt;

  logic is_bs, is_lf, is_ff, is_cr;
  logic in_bs, in_ctl;
  logic line_done, screen_done;
  logic [4:0] line_inc;

  assign is_bs = (byte_q == 8'h08);
  assign is_lf = (byte_q == 8'h0A);
  assign is_ff = (byte_q == 8'h0C);
  assign is_cr = (byte_q == 8'h0D);

  assign in_bs  = (Data == 8'h08);
  assign in_ctl = (Data == 8'h0A) || (Data == 8'h0C) ||
                  (Data == 8'h0D);

  assign line_done   = (scan_col == COL_END);
  assign screen_done = (scan_line == LINE_END);
  assign line_inc    = (cur_line == LINE_LAST) ? 5'd0
                                               : cur_line + 5'd1;

  assign Ready = (state == IDLE);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= CLR_SCREEN;
    else       state <= state_nxt;
  end

  // Next-state decode; the WRITE exit depends on the captured byte.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLR_SCREEN: if (screen_done) state_nxt = IDLE;
      IDLE:       if (Valid) state_nxt = WRITE;
      WRITE: begin
        unique case (1'b1)
          is_ff:   state_nxt = CLR_SCREEN;
          is_lf:   state_nxt = CLR_LINE;
          is_cr:   state_nxt = IDLE;
          is_bs:   state_nxt = IDLE;
          default: state_nxt = (cur_col == COL_LAST) ? CLR_LINE
                                                     : IDLE;
        endcase
      end
      CLR_LINE:   if (line_done) state_nxt = IDLE;
    endcase
  end

  // Cell write for the coming cycle; the accept edge emits the
  // character write so it is visible during WRITE.
  always_comb begin
    latch_nxt = 1'b0;
    line_nxt  = Line;
    char_nxt  = Character;
    glyph_nxt = Glyph;
    fg_nxt    = Foreground;
    bg_nxt    = Background;
    unique case (state)
      CLR_SCREEN: begin
        if (!screen_done) begin
          latch_nxt = 1'b1;
          line_nxt  = scan_line;
          char_nxt  = scan_col;
          glyph_nxt = BLANK_GLYPH;
          fg_nxt    = fg_q;
          bg_nxt    = bg_q;
        end
      end
      IDLE: begin
        if (Valid && in_bs && cur_col != 7'd0) begin
          latch_nxt = 1'b1;
          line_nxt  = cur_line;
          char_nxt  = cur_col - 7'd1;
          glyph_nxt = BLANK_GLYPH;
          fg_nxt    = Data_Fg;
          bg_nxt    = Data_Bg;
        end else if (Valid && !in_bs && !in_ctl) begin
          latch_nxt = 1'b1;
          line_nxt  = cur_line;
          char_nxt  = cur_col;
          glyph_nxt = Data;
          fg_nxt    = Data_Fg;
          bg_nxt    = Data_Bg;
        end
      end
      WRITE: latch_nxt = 1'b0;
      CLR_LINE: begin
        if (!line_done) begin
          latch_nxt = 1'b1;
          line_nxt  = cur_line;
          char_nxt  = scan_col;
          glyph_nxt = BLANK_GLYPH;
          fg_nxt    = fg_q;
          bg_nxt    = bg_q;
        end
      end
    endcase
  end

  // Registered cell-write outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Latch      <= 1'b0;
      Line       <= 5'd0;
      Character  <= 7'd0;
      Glyph      <= 8'd0;
      Foreground <= 12'd0;
      Background <= 12'd0;
    end else begin
      Latch      <= latch_nxt;
      Line       <= line_nxt;
      Character  <= char_nxt;
      Glyph      <= glyph_nxt;
      Foreground <= fg_nxt;
      Background <= bg_nxt;
    end
  end

  // Cursor, byte capture and clear scan counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cur_line  <= 5'd0;
      cur_col   <= 7'd0;
      byte_q    <= 8'd0;
      fg_q      <= 12'd0;
      bg_q      <= 12'd0;
      scan_col  <= 7'd0;
      scan_line <= 5'd0;
    end else begin
      unique case (state)
        CLR_SCREEN: begin
          if (screen_done) begin
            cur_line <= 5'd0;
            cur_col  <= 7'd0;
          end else if (scan_col == COL_LAST) begin
            scan_col  <= 7'd0;
            scan_line <= scan_line + 5'd1;
          end else begin
            scan_col <= scan_col + 7'd1;
          end
        end
        IDLE: begin
          if (Valid) begin
            byte_q <= Data;
            fg_q   <= Data_Fg;
            bg_q   <= Data_Bg;
          end
        end
        WRITE: begin
          scan_col  <= 7'd0;
          scan_line <= 5'd0;
          unique case (1'b1)
            is_ff: ;
            is_cr: cur_col <= 7'd0;
            is_lf: begin
              cur_col  <= 7'd0;
              cur_line <= line_inc;
            end
            is_bs: begin
              if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
            end
            default: begin
              if (cur_col == COL_LAST) begin
                cur_col  <= 7'd0;
                cur_line <= line_inc;
              end else begin
                cur_col <= cur_col + 7'd1;
              end
            end
          endcase
        end
        CLR_LINE: begin
          if (!line_done) scan_col <= scan_col + 7'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer.
// Expected values are hand-computed cursor positions.
module tb_text_console_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  Data = 8'h00;
  logic [11:0] Data_Fg = 12'h000;
  logic [11:0] Data_Bg = 12'h000;
  logic        Valid = 1'b0;
  logic        Ready;
  logic [4:0]  Line;
  logic [6:0]  Character;
  logic [7:0]  Glyph;
  logic [11:0] Foreground;
  logic [11:0] Background;
  logic        Latch;

  int n_checks = 0;
  int n_fail   = 0;

  logic        s_latch;
  logic [4:0]  s_line;
  logic [6:0]  s_char;
  logic [7:0]  s_glyph;
  logic [11:0] s_fg, s_bg;

  text_console_writer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Data       (Data),
    .Data_Fg    (Data_Fg),
    .Data_Bg    (Data_Bg),
    .Valid      (Valid),
    .Ready      (Ready),
    .Line       (Line),
    .Character  (Character),
    .Glyph      (Glyph),
    .Foreground (Foreground),
    .Background (Background),
    .Latch      (Latch)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3000; i++) begin
      if (Ready) break;
      @(negedge Clk);
    end
    if (!Ready) check("ready_timeout", 32'(Ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [11:0] f,
                      input logic [11:0] b);
    wait_ready();
    Data = d; Data_Fg = f; Data_Bg = b; Valid = 1'b1;
    @(posedge Clk);
    #1 Valid = 1'b0;
    @(negedge Clk);
    s_latch = Latch; s_line = Line; s_char = Character;
    s_glyph = Glyph; s_fg = Foreground; s_bg = Background;
  endtask

  task automatic settle(input logic [4:0] el, output int n,
                        output int bad);
    n = 0; bad = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (Ready) break;
      if (Latch) begin
        if (Line != el || Character != 7'(n) || Glyph != 8'h20)
          bad++;
        n++;
      end
    end
  endtask

  task automatic put(input logic [7:0] d);
    int n, b;
    send(d, 12'h123, 12'h456);
    settle(5'd0, n, b);
  endtask

  task automatic count_clear(output int n, output int span,
                             output logic [4:0] ll,
                             output logic [6:0] lc,
                             output logic [7:0] lg,
                             output logic [11:0] ffg);
    int first, last;
    n = 0; first = -1; last = -1;
    ll = '0; lc = '0; lg = '0; ffg = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (Ready) break;
      if (Latch) begin
        if (first < 0) begin
          first = i;
          ffg = Foreground;
        end
        last = i; n++;
        ll = Line; lc = Character; lg = Glyph;
      end
    end
    span = last - first + 1;
  endtask

  initial begin
    int n, b, span;
    logic [4:0]  ll;
    logic [6:0]  lc;
    logic [7:0]  lg;
    logic [11:0] ffg;

    repeat (3) @(negedge Clk);
    check("rst_latch", 32'(Latch), 32'd0);
    check("rst_line", 32'(Line), 32'd0);
    check("rst_glyph", 32'(Glyph), 32'd0);
    check("rst_ready", 32'(Ready), 32'd0);
    Reset = 1'b0;

    count_clear(n, span, ll, lc, lg, ffg);
    check("pwr_clear_n", 32'(n), 32'd2400);
    check("pwr_clear_span", 32'(span), 32'd2400);
    check("pwr_last_line", 32'(ll), 32'd29);
    check("pwr_last_char", 32'(lc), 32'd79);
    check("pwr_last_glyph", 32'(lg), 32'h20);
    check("pwr_ready", 32'(Ready), 32'd1);
    check("pwr_idle_latch", 32'(Latch), 32'd0);

    send(8'h41, 12'hFFF, 12'h00F);
    check("a_latch", 32'(s_latch), 32'd1);
    check("a_line", 32'(s_line), 32'd0);
    check("a_char", 32'(s_char), 32'd0);
    check("a_glyph", 32'(s_glyph), 32'h41);
    check("a_fg", 32'(s_fg), 32'hFFF);
    check("a_bg", 32'(s_bg), 32'h00F);
    check("a_write_ready", 32'(Ready), 32'd0);
    @(negedge Clk);
    check("a_ready_back", 32'(Ready), 32'd1);
    check("a_idle_latch", 32'(Latch), 32'd0);
    send(8'h42, 12'h0F0, 12'h000);
    check("b_char", 32'(s_char), 32'd1);
    check("b_glyph", 32'(s_glyph), 32'h42);
    settle(5'd0, n, b);
    check("b_no_clear", 32'(n), 32'd0);

    put(8'h0D);
    for (int i = 0; i < 80; i++) begin
      send(8'h61 + 8'(i % 26), 12'h111, 12'h222);
      if (i == 79) begin
        check("row_last_char", 32'(s_char), 32'd79);
        check("row_last_line", 32'(s_line), 32'd0);
        settle(5'd1, n, b);
        check("wrap_clr_n", 32'(n), 32'd80);
        check("wrap_clr_bad", 32'(b), 32'd0);
      end else begin
        settle(5'd0, n, b);
      end
    end
    send(8'h78, 12'h111, 12'h222);
    check("wrap_next_line", 32'(s_line), 32'd1);
    check("wrap_next_char", 32'(s_char), 32'd0);
    settle(5'd0, n, b);

    put(8'h0A);
    send(8'h08, 12'h111, 12'h222);
    check("bs0_latch", 32'(s_latch), 32'd0);
    settle(5'd0, n, b);
    check("bs0_no_write", 32'(n), 32'd0);
    for (int i = 0; i < 7; i++) begin
      send(8'h30 + 8'(i), 12'h111, 12'h222);
      if (i == 0) begin
        check("bs0_cur_line", 32'(s_line), 32'd2);
        check("bs0_cur_char", 32'(s_char), 32'd0);
      end
      settle(5'd0, n, b);
    end
    send(8'h08, 12'h333, 12'h444);
    check("bs7_latch", 32'(s_latch), 32'd1);
    check("bs7_line", 32'(s_line), 32'd2);
    check("bs7_char", 32'(s_char), 32'd6);
    check("bs7_glyph", 32'(s_glyph), 32'h20);
    settle(5'd0, n, b);
    send(8'h51, 12'h111, 12'h222);
    check("bs_next_char", 32'(s_char), 32'd6);
    settle(5'd0, n, b);

    for (int i = 0; i < 27; i++) put(8'h0A);
    for (int i = 0; i < 5; i++) put(8'h2E);
    send(8'h0A, 12'h0AA, 12'h055);
    check("lf29_latch", 32'(s_latch), 32'd0);
    settle(5'd0, n, b);
    check("lf29_clr_n", 32'(n), 32'd80);
    check("lf29_clr_bad", 32'(b), 32'd0);
    send(8'h50, 12'h111, 12'h222);
    check("lf29_next_line", 32'(s_line), 32'd0);
    check("lf29_next_char", 32'(s_char), 32'd0);
    settle(5'd0, n, b);

    for (int i = 0; i < 3; i++) put(8'h0A);
    for (int i = 0; i < 40; i++) put(8'h2D);
    send(8'h0D, 12'h111, 12'h222);
    check("cr_latch", 32'(s_latch), 32'd0);
    settle(5'd0, n, b);
    check("cr_no_write", 32'(n), 32'd0);
    send(8'h52, 12'h111, 12'h222);
    check("cr_next_line", 32'(s_line), 32'd3);
    check("cr_next_char", 32'(s_char), 32'd0);
    settle(5'd0, n, b);

    send(8'h0A, 12'h111, 12'h222);
    n = 0; b = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (Ready) break;
      Valid = 1'b1;
      Data = 8'h30 + 8'(i);
      if (Latch) begin
        n++;
        if (Glyph != 8'h20 || Line != 5'd4) b++;
      end
    end
    check("hold_clr_n", 32'(n), 32'd80);
    check("hold_clr_bad", 32'(b), 32'd0);
    Data = 8'h5A;
    @(posedge Clk);
    #1 Valid = 1'b0;
    @(negedge Clk);
    check("hold_glyph", 32'(Glyph), 32'h5A);
    check("hold_line", 32'(Line), 32'd4);
    check("hold_char", 32'(Character), 32'd0);
    settle(5'd0, n, b);
    send(8'h59, 12'h111, 12'h222);
    check("hold_once_char", 32'(s_char), 32'd1);
    settle(5'd0, n, b);

    send(8'h0C, 12'hABC, 12'hDEF);
    check("ff_latch", 32'(s_latch), 32'd0);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (Latch) n++;
      if (n == 1000) break;
    end
    check("ff_mid_count", 32'(n), 32'd1000);
    Reset = 1'b1;
    #1;
    check("async_latch_drop", 32'(Latch), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    count_clear(n, span, ll, lc, lg, ffg);
    check("restart_n", 32'(n), 32'd2400);
    check("restart_span", 32'(span), 32'd2400);
    check("restart_last_line", 32'(ll), 32'd29);
    check("restart_last_char", 32'(lc), 32'd79);
    check("restart_fg", 32'(ffg), 32'h000);

    send(8'h0C, 12'hABC, 12'hDEF);
    count_clear(n, span, ll, lc, lg, ffg);
    check("ff_clear_n", 32'(n), 32'd2400);
    check("ff_clear_fg", 32'(ffg), 32'hABC);
    send(8'h5A, 12'h111, 12'h222);
    check("ff_home_line", 32'(s_line), 32'd0);
    check("ff_home_char", 32'(s_char), 32'd0);
    settle(5'd0, n, b);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
